// File: rtl/parking_pkg.sv
// parking_pkg: shared FSM state type and default sizing for the parking gate controller
package parking_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OPEN_IN  = 2'd1,
      OPEN_OUT = 2'd2
   } gate_state_t;

   localparam int DEF_CAPACITY         = 8;
   localparam int DEF_GATE_OPEN_CYCLES = 16;

endpackage

// File: rtl/parking_gate_controller_rise_detect.sv
// rise_detect: registers the previous button level and flags a low-to-high transition
module rise_detect (
   input  logic clk,
   input  logic rstN,
   input  logic level,
   output logic rise
);

   logic r_prev;

   // previous level tracks the input every cycle, regardless of FSM state
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) r_prev <= 1'b0;
      else       r_prev <= level;
   end

   assign rise = level & ~r_prev;

endmodule

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: barrier FSM with occupancy counting, gate hold timer and event pulses
module parking_gate_controller
   import parking_pkg::*;
#(
   parameter  int CAPACITY         = DEF_CAPACITY,
   parameter  int GATE_OPEN_CYCLES = DEF_GATE_OPEN_CYCLES,
   localparam int CNT_W            = $clog2(CAPACITY + 1),
   localparam int TMR_W            = $clog2(GATE_OPEN_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             entryButton,
   input  logic             exitButton,
   output logic             gateOpen,
   output logic [CNT_W-1:0] occupancy,
   output logic             full,
   output logic             empty,
   output logic             entryDenied,
   output logic             exitError
);

   localparam logic [CNT_W-1:0] CAP_V  = CNT_W'(CAPACITY);
   localparam logic [TMR_W-1:0] TMR_LD = TMR_W'(GATE_OPEN_CYCLES - 1);

   gate_state_t      r_state, w_state_nxt;
   logic [TMR_W-1:0] r_timer, w_timer_nxt;
   logic [CNT_W-1:0] r_occ, w_occ_nxt;
   logic             r_gate, w_gate_nxt;
   logic             r_full, r_empty, r_denied, r_exit_err;
   logic             r_armed;
   logic             w_entry_rise, w_exit_rise;
   logic             w_idle, w_do_exit, w_do_entry, w_denied, w_exit_err, w_tmr_done;

   rise_detect u_entry_rise (.clk(clk), .rstN(rstN), .level(entryButton), .rise(w_entry_rise));
   rise_detect u_exit_rise  (.clk(clk), .rstN(rstN), .level(exitButton),  .rise(w_exit_rise));

   // decode requests (exit wins over entry) and compute next state, timer, count and gate
   always_comb begin
      w_idle      = r_armed && (r_state == IDLE);
      w_do_exit   = w_idle & w_exit_rise & (r_occ != '0);
      w_exit_err  = w_idle & w_exit_rise & (r_occ == '0);
      w_do_entry  = w_idle & w_entry_rise & ~w_exit_rise & (r_occ != CAP_V);
      w_denied    = w_idle & w_entry_rise & ~w_exit_rise & (r_occ == CAP_V);
      w_tmr_done  = (r_state != IDLE) && (r_timer == '0);
      w_occ_nxt   = w_do_exit ? r_occ - CNT_W'(1) : w_do_entry ? r_occ + CNT_W'(1) : r_occ;
      w_state_nxt = w_do_exit ? OPEN_OUT : w_do_entry ? OPEN_IN : w_tmr_done ? IDLE : r_state;
      w_timer_nxt = (w_do_exit | w_do_entry) ? TMR_LD :
                    ((r_state != IDLE) && (r_timer != '0)) ? r_timer - TMR_W'(1) : r_timer;
      w_gate_nxt  = (w_do_exit | w_do_entry) ? 1'b1 : w_tmr_done ? 1'b0 : r_gate;
   end

   // register all state and outputs; r_armed masks the first edge after reset so a
   // button held through reset release does not count as a fresh press
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state    <= IDLE;
         r_timer    <= '0;
         r_occ      <= '0;
         r_gate     <= 1'b0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_denied   <= 1'b0;
         r_exit_err <= 1'b0;
         r_armed    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_timer    <= w_timer_nxt;
         r_occ      <= w_occ_nxt;
         r_gate     <= w_gate_nxt;
         r_full     <= (w_occ_nxt == CAP_V);
         r_empty    <= (w_occ_nxt == '0);
         r_denied   <= w_denied;
         r_exit_err <= w_exit_err;
         r_armed    <= 1'b1;
      end
   end

   assign gateOpen    = r_gate;
   assign occupancy   = r_occ;
   assign full        = r_full;
   assign empty       = r_empty;
   assign entryDenied = r_denied;
   assign exitError   = r_exit_err;

endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: table-driven and directed checks of the gate controller at CAPACITY=2, GATE_OPEN_CYCLES=4
module tb_parking_gate_controller;

   localparam int CAP = 2;
   localparam int GOC = 4;
   localparam int CW  = $clog2(CAP + 1);
   localparam int EW  = CW + 5;

   logic          clk = 1'b0;
   logic          rstN = 1'b0;
   logic          entryButton = 1'b0;
   logic          exitButton = 1'b0;
   logic          gateOpen, full, empty, entryDenied, exitError;
   logic [CW-1:0] occupancy;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic          en;
      logic          ex;
      logic [EW-1:0] exp;
      string         name;
   } vec_t;

   vec_t tbl[$];

   parking_gate_controller #(.CAPACITY(CAP), .GATE_OPEN_CYCLES(GOC)) dut (
      .clk(clk), .rstN(rstN), .entryButton(entryButton), .exitButton(exitButton),
      .gateOpen(gateOpen), .occupancy(occupancy), .full(full), .empty(empty),
      .entryDenied(entryDenied), .exitError(exitError)
   );

   always #5 clk = ~clk;

   function automatic logic [EW-1:0] e(input int g, input int o, input int f, input int m, input int d, input int x);
      e = {g[0], o[CW-1:0], f[0], m[0], d[0], x[0]};
   endfunction

   task automatic add(input string name, input logic en, input logic ex, input logic [EW-1:0] exp);
      vec_t v;
      v.en = en; v.ex = ex; v.exp = exp; v.name = name;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [EW-1:0] exp);
      logic [EW-1:0] got;
      got = {gateOpen, occupancy, full, empty, entryDenied, exitError};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: gate/occ/full/empty/denied/exiterr got=%b required=%b", name, got, exp);
      end
   endtask

   task automatic step(input string name, input logic en, input logic ex, input logic [EW-1:0] exp);
      entryButton = en;
      exitButton  = ex;
      @(posedge clk);
      #1;
      chk(name, exp);
   endtask

   initial begin
      // expected columns: gate, occupancy, full, empty, entryDenied, exitError
      add("arm",           0, 0, e(0,0,0,1,0,0));
      add("entry_held_1",  1, 0, e(1,1,0,0,0,0));
      add("entry_held_2",  1, 0, e(1,1,0,0,0,0));
      add("entry_held_3",  1, 0, e(1,1,0,0,0,0));
      add("gate_open_4",   0, 0, e(1,1,0,0,0,0));
      add("gate_close_1",  0, 0, e(0,1,0,0,0,0));
      add("entry_to_full", 1, 0, e(1,2,1,0,0,0));
      add("full_open_2",   0, 0, e(1,2,1,0,0,0));
      add("full_open_3",   0, 0, e(1,2,1,0,0,0));
      add("full_open_4",   0, 0, e(1,2,1,0,0,0));
      add("full_closed",   0, 0, e(0,2,1,0,0,0));
      add("denied_pulse",  1, 0, e(0,2,1,0,1,0));
      add("denied_once",   1, 0, e(0,2,1,0,0,0));
      add("release_entry", 0, 0, e(0,2,1,0,0,0));
      add("both_rise",     1, 1, e(1,1,0,0,0,0));
      add("both_open_2",   0, 0, e(1,1,0,0,0,0));
      add("both_open_3",   0, 0, e(1,1,0,0,0,0));
      add("both_open_4",   0, 0, e(1,1,0,0,0,0));
      add("both_closed",   0, 0, e(0,1,0,0,0,0));
      add("exit_to_empty", 0, 1, e(1,0,0,1,0,0));
      add("exit_open_2",   0, 0, e(1,0,0,1,0,0));
      add("exit_open_3",   0, 0, e(1,0,0,1,0,0));
      add("exit_open_4",   0, 0, e(1,0,0,1,0,0));
      add("exit_closed",   0, 0, e(0,0,0,1,0,0));
      add("exit_err",      0, 1, e(0,0,0,1,0,1));
      add("exit_err_once", 0, 1, e(0,0,0,1,0,0));
      add("exit_release",  0, 0, e(0,0,0,1,0,0));

      #12;
      chk("reset_state", e(0,0,0,1,0,0));
      rstN = 1'b1;
      #1;
      foreach (tbl[i]) step(tbl[i].name, tbl[i].en, tbl[i].ex, tbl[i].exp);

      // second entry rise while the gate is open is dropped
      step("drop_first",   1, 0, e(1,1,0,0,0,0));
      step("drop_low",     0, 0, e(1,1,0,0,0,0));
      step("drop_rise2",   1, 0, e(1,1,0,0,0,0));
      step("drop_low2",    0, 0, e(1,1,0,0,0,0));
      step("drop_closed",  0, 0, e(0,1,0,0,0,0));

      // async reset mid OPEN_IN with occupancy 1, button held through release
      rstN = 1'b0;
      #2;
      chk("reset_idle", e(0,0,0,1,0,0));
      rstN = 1'b1;
      step("rearm",        0, 0, e(0,0,0,1,0,0));
      step("rst_entry",    1, 0, e(1,1,0,0,0,0));
      step("rst_entry_h",  1, 0, e(1,1,0,0,0,0));
      #3;
      rstN = 1'b0;
      #1;
      chk("async_reset",   e(0,0,0,1,0,0));
      #2;
      rstN = 1'b1;
      step("held_rel_1",   1, 0, e(0,0,0,1,0,0));
      step("held_rel_2",   1, 0, e(0,0,0,1,0,0));
      step("held_low",     0, 0, e(0,0,0,1,0,0));
      step("held_repress", 1, 0, e(1,1,0,0,0,0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
